// File: rtl/plot_arb_pkg.sv
// Shared types and constants for the framebuffer write-port arbiter.
package plot_arb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COORD_W  = 8;
    localparam int COLOR_W  = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/plot_arbiter_rr_picker.sv
// Round-robin requester search: first asserted req at or after start, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         start,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        // Outer loop sets search order; inner loop maps the rotated slot back to a requester.
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == (int'(start) + k) % NUM_REQ) && req[i]) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin, burst-bounded arbiter for the single framebuffer write port.
// PLOT_ARB_BOUNDS_CHECK_EN adds off-screen pixel dropping and the drop_cnt output.
module plot_arbiter
    import plot_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       plot,
    output logic [COORD_W-1:0]         x_out,
    output logic [COORD_W-1:0]         y_out,
    output logic [COLOR_W-1:0]         color_out,
    output logic [2:0]                 owner,
    output logic                       busy
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int                BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NUM_REQ - 1);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [2:0]           owner_q;
    logic [2:0]           last_owner_q;
    logic [BEAT_W-1:0]    beat_q;
    logic                 plot_q;
    pixel_t               pix_q;

    logic [2:0]           pick_base;
    logic [2:0]           pick_start;
    logic [NUM_REQ-1:0]   pick;
    logic                 found;
    logic [2:0]           pick_idx;
    logic                 xfer;
    logic                 release_burst;
    pixel_t               cur_pix;

    // Idle searches past the previous owner; a releasing burst searches past the current one.
    assign pick_base  = (state_q == IDLE) ? last_owner_q : owner_q;
    assign pick_start = (pick_base >= LAST_IDX) ? 3'd0 : pick_base + 3'd1;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req),
        .start (pick_start),
        .pick  (pick),
        .found (found)
    );

    assign pick_idx      = onehot_to_idx(8'(pick));
    assign xfer          = |(gnt_q & req);
    assign release_burst = (state_q == BURST) && (!xfer || (beat_q == LAST_BEAT));

    always_comb begin
        cur_pix = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                cur_pix.x     = req_x[i*COORD_W +: COORD_W];
                cur_pix.y     = req_y[i*COORD_W +: COORD_W];
                cur_pix.color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

`ifdef PLOT_ARB_BOUNDS_CHECK_EN
    logic [15:0] drop_cnt_q;
    logic        in_range;

    assign in_range = (cur_pix.x < COORD_W'(SCREEN_W)) && (cur_pix.y < COORD_W'(SCREEN_H));
    assign drop_cnt = drop_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            beat_q       <= '0;
            plot_q       <= 1'b0;
            pix_q        <= '0;
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            plot_q <= 1'b0;
            if (xfer) begin
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
                // Off-screen pixels still consume their beat but never reach the adapter.
                if (in_range) begin
                    plot_q <= 1'b1;
                    pix_q  <= cur_pix;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
`else
                plot_q <= 1'b1;
                pix_q  <= cur_pix;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= BURST;
                        gnt_q   <= pick;
                        owner_q <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                BURST: begin
                    if (release_burst) begin
                        last_owner_q <= owner_q;
                        if (found) begin
                            gnt_q   <= pick;
                            owner_q <= pick_idx;
                            beat_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign plot      = plot_q;
    assign x_out     = pix_q.x;
    assign y_out     = pix_q.y;
    assign color_out = pix_q.color;
    assign owner     = owner_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (NUM_REQ=4, MAX_BURST=4); honours PLOT_ARB_BOUNDS_CHECK_EN.
module tb_plot_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [47:0] req_color;
    logic [3:0]  gnt;
    logic        plot;
    logic [7:0]  x_out;
    logic [7:0]  y_out;
    logic [11:0] color_out;
    logic [2:0]  owner;
    logic        busy;
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
    logic [15:0] drop_cnt;
`endif

    int vectors;
    int miscompares;
    logic [7:0]  lx, ly;
    logic [11:0] lc;

    plot_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .gnt       (gnt),
        .plot      (plot),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out),
        .owner     (owner),
        .busy      (busy)
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel stream of requester i, c-th pixel.
    function automatic logic [7:0]  px(int i, int c); return 8'(i * 50 + c); endfunction
    function automatic logic [7:0]  py(int i, int c); return 8'(i + c); endfunction
    function automatic logic [11:0] pc(int i, int c); return 12'(i * 256 + c); endfunction

    task automatic set_pix(int i, logic [7:0] x, logic [7:0] y, logic [11:0] c);
        req_x[i*8 +: 8]      = x;
        req_y[i*8 +: 8]      = y;
        req_color[i*12 +: 12] = c;
    endtask

    task automatic drive_pix(int i, int c);
        set_pix(i, px(i, c), py(i, c), pc(i, c));
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        req = '0; req_x = '0; req_y = '0; req_color = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt, plot, x_out, y_out, color_out, owner, busy} !== {4'b0, 1'b0, 8'd0, 8'd0, 12'd0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got gnt=%b plot=%b x=%0d y=%0d color=%h owner=%0d busy=%b, want all zero",
                     gnt, plot, x_out, y_out, color_out, owner, busy);
        end
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
        vectors++;
        if (drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        lx = 8'd0; ly = 8'd0; lc = 12'd0;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int cnt [4];
        int o, no;
        logic [3:0] eg;
        cnt = '{0, 0, 0, 0};
        req = 4'b0101;
        drive_pix(0, 0); drive_pix(2, 0);
        @(negedge clk);
        vectors++;
        if ({gnt, plot, owner, busy} !== {4'b0001, 1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rr_first_grant: got gnt=%b plot=%b owner=%0d busy=%b want gnt=0001 plot=0 owner=0 busy=1",
                     gnt, plot, owner, busy);
        end
        for (int k = 0; k < 16; k++) begin
            drive_pix(0, cnt[0]); drive_pix(2, cnt[2]);
            o  = ((k / 4) % 2 == 0) ? 0 : 2;
            no = (((k + 1) / 4) % 2 == 0) ? 0 : 2;
            eg = 4'(1 << no);
            @(negedge clk);
            vectors++;
            if ({plot, x_out, y_out, color_out, gnt, owner} !==
                {1'b1, px(o, cnt[o]), py(o, cnt[o]), pc(o, cnt[o]), eg, 3'(no)}) begin
                miscompares++;
                $display("FAIL rr_beat%0d: got plot=%b x=%0d y=%0d color=%h gnt=%b owner=%0d want plot=1 x=%0d y=%0d color=%h gnt=%b owner=%0d",
                         k, plot, x_out, y_out, color_out, gnt, owner, px(o, cnt[o]), py(o, cnt[o]), pc(o, cnt[o]), eg, no);
            end
            lx = px(o, cnt[o]); ly = py(o, cnt[o]); lc = pc(o, cnt[o]);
            cnt[o]++;
        end
        req = '0;
        @(negedge clk);
        vectors++;
        if ({plot, gnt, busy} !== {1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rr_release: got plot=%b gnt=%b busy=%b want 0 0000 0", plot, gnt, busy);
        end
    endtask

    task automatic test_drop;
        req = 4'b1010;
        drive_pix(1, 0); drive_pix(3, 0);
        @(negedge clk);
        vectors++;
        if ({gnt, owner} !== {4'b0010, 3'd1}) begin
            miscompares++;
            $display("FAIL drop_grant1: got gnt=%b owner=%0d want 0010 1", gnt, owner);
        end
        for (int k = 0; k < 3; k++) begin
            drive_pix(1, k);
            @(negedge clk);
            vectors++;
            if ({plot, x_out, y_out, color_out, gnt} !== {1'b1, px(1, k), py(1, k), pc(1, k), 4'b0010}) begin
                miscompares++;
                $display("FAIL drop_xfer%0d: got plot=%b x=%0d y=%0d color=%h gnt=%b want plot=1 x=%0d y=%0d color=%h gnt=0010",
                         k, plot, x_out, y_out, color_out, gnt, px(1, k), py(1, k), pc(1, k));
            end
        end
        req = 4'b1000;
        @(negedge clk);
        vectors++;
        if ({plot, gnt, owner, x_out} !== {1'b0, 4'b1000, 3'd3, px(1, 2)}) begin
            miscompares++;
            $display("FAIL drop_switch: got plot=%b gnt=%b owner=%0d x=%0d want plot=0 gnt=1000 owner=3 x=%0d",
                     plot, gnt, owner, x_out, px(1, 2));
        end
        drive_pix(3, 0);
        @(negedge clk);
        vectors++;
        if ({plot, x_out, y_out, color_out} !== {1'b1, px(3, 0), py(3, 0), pc(3, 0)}) begin
            miscompares++;
            $display("FAIL drop_req3_xfer: got plot=%b x=%0d y=%0d color=%h want plot=1 x=%0d y=%0d color=%h",
                     plot, x_out, y_out, color_out, px(3, 0), py(3, 0), pc(3, 0));
        end
        lx = px(3, 0); ly = py(3, 0); lc = pc(3, 0);
        req = '0;
        @(negedge clk);
        vectors++;
        if ({plot, gnt, busy} !== {1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_idle: got plot=%b gnt=%b busy=%b want 0 0000 0", plot, gnt, busy);
        end
    endtask

    task automatic test_single;
        req = 4'b0001;
        drive_pix(0, 0);
        @(negedge clk);
        vectors++;
        if ({gnt, plot} !== {4'b0001, 1'b0}) begin
            miscompares++;
            $display("FAIL single_grant: got gnt=%b plot=%b want 0001 0", gnt, plot);
        end
        // Burst limit of 4 re-grants requester 0 with no bubble, so 40 back-to-back plots.
        for (int k = 0; k < 40; k++) begin
            drive_pix(0, k);
            @(negedge clk);
            vectors++;
            if ({plot, x_out, y_out, color_out, gnt, owner} !== {1'b1, px(0, k), py(0, k), pc(0, k), 4'b0001, 3'd0}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got plot=%b x=%0d y=%0d color=%h gnt=%b owner=%0d want plot=1 x=%0d y=%0d color=%h gnt=0001 owner=0",
                         k, plot, x_out, y_out, color_out, gnt, owner, px(0, k), py(0, k), pc(0, k));
            end
        end
        lx = px(0, 39); ly = py(0, 39); lc = pc(0, 39);
        req = '0;
        @(negedge clk);
        vectors++;
        if ({plot, gnt, busy} !== {1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_release: got plot=%b gnt=%b busy=%b want 0 0000 0", plot, gnt, busy);
        end
    endtask

    task automatic test_reset_midburst;
        req = 4'b0100;
        drive_pix(2, 0);
        @(negedge clk);
        vectors++;
        if ({gnt, owner} !== {4'b0100, 3'd2}) begin
            miscompares++;
            $display("FAIL rst_mid_grant: got gnt=%b owner=%0d want 0100 2", gnt, owner);
        end
        @(negedge clk);
        vectors++;
        if ({plot, x_out} !== {1'b1, px(2, 0)}) begin
            miscompares++;
            $display("FAIL rst_mid_xfer: got plot=%b x=%0d want 1 %0d", plot, x_out, px(2, 0));
        end
        drive_pix(2, 1); drive_pix(0, 0);
        req = 4'b0101;
        resetn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({gnt, plot, x_out, y_out, color_out, owner, busy} !== {4'b0, 1'b0, 8'd0, 8'd0, 12'd0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_state: got gnt=%b plot=%b x=%0d y=%0d color=%h owner=%0d busy=%b want all zero",
                     gnt, plot, x_out, y_out, color_out, owner, busy);
        end
        lx = 8'd0; ly = 8'd0; lc = 12'd0;
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({gnt, owner, busy, plot} !== {4'b0001, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_regrant: got gnt=%b owner=%0d busy=%b plot=%b want 0001 0 1 0", gnt, owner, busy, plot);
        end
        req = '0;
        @(negedge clk);
        vectors++;
        if ({gnt, busy, plot, x_out} !== {4'b0, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_idle: got gnt=%b busy=%b plot=%b x=%0d want 0000 0 0 0", gnt, busy, plot, x_out);
        end
    endtask

    task automatic test_bounds;
        req = 4'b0010;
        set_pix(1, 8'd159, 8'd119, 12'hABC);
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL bounds_grant: got gnt=%b want 0010", gnt);
        end
        @(negedge clk);
        vectors++;
        if ({plot, x_out, y_out, color_out} !== {1'b1, 8'd159, 8'd119, 12'hABC}) begin
            miscompares++;
            $display("FAIL bounds_edge_pixel: got plot=%b x=%0d y=%0d color=%h want 1 159 119 abc", plot, x_out, y_out, color_out);
        end
        set_pix(1, 8'd160, 8'd0, 12'h123);
        @(negedge clk);
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
        vectors++;
        if ({plot, x_out, y_out, color_out, drop_cnt} !== {1'b0, 8'd159, 8'd119, 12'hABC, 16'd1}) begin
            miscompares++;
            $display("FAIL bounds_x160: got plot=%b x=%0d y=%0d color=%h drop=%0d want 0 159 119 abc 1",
                     plot, x_out, y_out, color_out, drop_cnt);
        end
`else
        vectors++;
        if ({plot, x_out, y_out, color_out} !== {1'b1, 8'd160, 8'd0, 12'h123}) begin
            miscompares++;
            $display("FAIL bounds_x160: got plot=%b x=%0d y=%0d color=%h want 1 160 0 123", plot, x_out, y_out, color_out);
        end
`endif
        set_pix(1, 8'd0, 8'd120, 12'h456);
        @(negedge clk);
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
        vectors++;
        if ({plot, x_out, y_out, color_out, drop_cnt, gnt} !== {1'b0, 8'd159, 8'd119, 12'hABC, 16'd2, 4'b0010}) begin
            miscompares++;
            $display("FAIL bounds_y120: got plot=%b x=%0d y=%0d color=%h drop=%0d gnt=%b want 0 159 119 abc 2 0010",
                     plot, x_out, y_out, color_out, drop_cnt, gnt);
        end
        lx = 8'd159; ly = 8'd119; lc = 12'hABC;
`else
        vectors++;
        if ({plot, x_out, y_out, color_out, gnt} !== {1'b1, 8'd0, 8'd120, 12'h456, 4'b0010}) begin
            miscompares++;
            $display("FAIL bounds_y120: got plot=%b x=%0d y=%0d color=%h gnt=%b want 1 0 120 456 0010",
                     plot, x_out, y_out, color_out, gnt);
        end
        lx = 8'd0; ly = 8'd120; lc = 12'h456;
`endif
        req = '0;
        @(negedge clk);
        vectors++;
        if ({plot, gnt, busy} !== {1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL bounds_release: got plot=%b gnt=%b busy=%b want 0 0000 0", plot, gnt, busy);
        end
    endtask

    task automatic test_idle;
        req = '0;
        set_pix(0, 8'h11, 8'h22, 12'h333);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({busy, gnt, plot, x_out, y_out, color_out} !== {1'b0, 4'b0, 1'b0, lx, ly, lc}) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: got busy=%b gnt=%b plot=%b x=%0d y=%0d color=%h want 0 0000 0 %0d %0d %h",
                         k, busy, gnt, plot, x_out, y_out, color_out, lx, ly, lc);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_drop();
        test_single();
        test_reset_midburst();
        test_bounds();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
